// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
//
// Dynamic branch predictor for the 5-stage pipeline. It is looked up
// combinationally in IF with the current PC and supplies the predicted next PC
// to the PC mux. It is trained from ID/EX when a branch resolves.
//
// Organisation: a direct-mapped table. Each entry holds a valid bit, a partial
// tag, a saturating counter and a branch target. The table is RAM-style, with
// no per-entry reset. A sweep FSM initialises it after reset and after every
// clear request.
//
// Address fields (IDX_W = log2(ENTRIES)):
//   index = pc[IDX_W+1:2]
//   tag   = pc[IDX_W+TAG_W+1:IDX_W+2]
//
// Optional build macro:
//   BP_STATS_EN - adds update / misprediction statistics counters and the
//                 upd_pred_taken_i input that feeds them.
//
// Ports:
//   clk_i            in   1       clock, rising edge
//   rst_n_i          in   1       asynchronous active-low reset
//   clear_i          in   1       synchronous request to invalidate the table
//   lookup_pc_i      in   ADDR_W  IF-stage PC
//   pred_hit_o       out  1       valid entry with matching tag
//   pred_taken_o     out  1       predicted taken
//   pred_next_pc_o   out  ADDR_W  predicted next PC
//   upd_valid_i      in   1       a branch resolved this cycle
//   upd_pc_i         in   ADDR_W  PC of the resolved branch
//   upd_taken_i      in   1       actual outcome
//   upd_target_i     in   ADDR_W  actual taken target
//   busy_o           out  1       sweep in progress
//   (BP_STATS_EN only)
//   upd_pred_taken_i in   1       prediction used for the resolving branch
//   stat_updates_o   out  32      accepted updates (saturating)
//   stat_mispred_o   out  32      accepted mispredicted updates (saturating)
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_next_pc_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic              busy_o
`ifdef BP_STATS_EN
    ,
    input  logic              upd_pred_taken_i,
    output logic [31:0]       stat_updates_o,
    output logic [31:0]       stat_mispred_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_N = CNT_WEAK_T - CNT_W'(1);

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } state_e;

    // ------------------------------------------------------------------------
    // Table storage (no reset; initialised by the sweep)
    // ------------------------------------------------------------------------
    logic              valid_mem [ENTRIES];
    logic [TAG_W-1:0]  tag_mem   [ENTRIES];
    logic [CNT_W-1:0]  cnt_mem   [ENTRIES];
    logic [ADDR_W-1:0] tgt_mem   [ENTRIES];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_valid;
    logic [TAG_W-1:0]  wr_tag;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] wr_tgt;
    logic              upd_accept;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [ADDR_W-1:0] lk_seq_pc;

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [CNT_W-1:0]  up_cnt;
    logic [CNT_W-1:0]  up_cnt_next;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    assign busy_o = (state_q == ST_SWEEP);

    // ------------------------------------------------------------------------
    // Combinational lookup. The table contents are meaningless during a sweep,
    // so the prediction is forced to sequential fall-through while busy.
    // ------------------------------------------------------------------------
    always_comb begin
        lk_seq_pc = lookup_pc_i + ADDR_W'(4);
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        if (!busy_o) begin
            lk_hit   = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
            lk_taken = lk_hit && cnt_mem[lk_idx][CNT_W-1];
        end
        pred_hit_o     = lk_hit;
        pred_taken_o   = lk_taken;
        pred_next_pc_o = lk_taken ? tgt_mem[lk_idx] : lk_seq_pc;
    end

    // ------------------------------------------------------------------------
    // Read side of the update port: current entry state for the resolving
    // branch, and its counter after one saturating step toward the outcome.
    // ------------------------------------------------------------------------
    always_comb begin
        up_hit      = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
        up_cnt      = cnt_mem[up_idx];
        up_cnt_next = up_cnt;
        if (upd_taken_i) begin
            if (up_cnt != CNT_MAX) begin
                up_cnt_next = up_cnt + CNT_W'(1);
            end
        end else begin
            if (up_cnt != '0) begin
                up_cnt_next = up_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sweep FSM next state and the single table write port. The sweep owns the
    // write port while busy; in IDLE the resolving branch uses it. A clear
    // takes priority over an update arriving in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_en      = 1'b0;
        wr_idx     = idx_q;
        wr_valid   = 1'b0;
        wr_tag     = '0;
        wr_cnt     = CNT_WEAK_N;
        wr_tgt     = '0;
        upd_accept = 1'b0;

        case (state_q)
            ST_SWEEP: begin
                wr_en  = 1'b1;
                wr_idx = idx_q;
                if (clear_i) begin
                    idx_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end else if (upd_valid_i) begin
                    upd_accept = 1'b1;
                    wr_idx     = up_idx;
                    wr_tag     = up_tag;
                    wr_valid   = 1'b1;
                    if (up_hit) begin
                        wr_en  = 1'b1;
                        wr_cnt = up_cnt_next;
                        wr_tgt = upd_taken_i ? upd_target_i : tgt_mem[up_idx];
                    end else if (upd_taken_i) begin
                        // Allocate (or replace an aliasing entry) as weakly taken.
                        wr_en  = 1'b1;
                        wr_cnt = CNT_WEAK_T;
                        wr_tgt = upd_target_i;
                    end
                end
            end

            default: begin
                state_d = ST_SWEEP;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register: reset restarts the sweep from index 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Table write (RAM-style, no reset).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            tag_mem[wr_idx]   <= wr_tag;
            cnt_mem[wr_idx]   <= wr_cnt;
            tgt_mem[wr_idx]   <= wr_tgt;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // ------------------------------------------------------------------------
    // Statistics: only updates the table actually accepted are counted; both
    // counters saturate rather than wrap and are zeroed by a clear.
    // ------------------------------------------------------------------------
    always_comb begin
        stat_updates_d = stat_updates_q;
        stat_mispred_d = stat_mispred_q;
        if (clear_i) begin
            stat_updates_d = '0;
            stat_mispred_d = '0;
        end else if (upd_accept) begin
            if (stat_updates_q != 32'hFFFF_FFFF) begin
                stat_updates_d = stat_updates_q + 32'd1;
            end
            if ((upd_pred_taken_i != upd_taken_i) && (stat_mispred_q != 32'hFFFF_FFFF)) begin
                stat_mispred_d = stat_mispred_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_updates_q <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_updates_q <= stat_updates_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_updates_o = stat_updates_q;
    assign stat_mispred_o = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor
//
// Directed bench for branch_predictor (ENTRIES=16, TAG_W=8, CNT_W=2). The
// stimulus process pushes the expected lookup response into a queue for each
// vector; the monitor pops and compares at the falling edge, before the
// rising edge that commits any update driven in the same cycle.
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 32;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] next;
        logic        busy;
    } exp_t;

    logic              clk_i;
    logic              rst_n_i;
    logic              clear_i;
    logic [ADDR_W-1:0] lookup_pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_next_pc_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              busy_o;
`ifdef BP_STATS_EN
    logic              upd_pred_taken_i;
    logic [31:0]       stat_updates_o;
    logic [31:0]       stat_mispred_o;
`endif

    exp_t sb_q[$];
    logic strobe;
    int   vectors;
    int   miscompares;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .TAG_W   (8),
        .CNT_W   (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .clear_i          (clear_i),
        .lookup_pc_i      (lookup_pc_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_next_pc_o   (pred_next_pc_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .busy_o           (busy_o)
`ifdef BP_STATS_EN
        ,
        .upd_pred_taken_i (upd_pred_taken_i),
        .stat_updates_o   (stat_updates_o),
        .stat_mispred_o   (stat_mispred_o)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Compare one popped expectation against the live DUT outputs.
    task automatic checkOutput(input exp_t e);
        vectors++;
        if (pred_hit_o !== e.hit || pred_taken_o !== e.taken ||
            pred_next_pc_o !== e.next || busy_o !== e.busy) begin
            miscompares++;
            $display("[TB] FAIL %s: got hit=%0b taken=%0b next=%h busy=%0b, want hit=%0b taken=%0b next=%h busy=%0b",
                     e.name, pred_hit_o, pred_taken_o, pred_next_pc_o, busy_o,
                     e.hit, e.taken, e.next, e.busy);
        end
    endtask

    // Monitor: whenever a vector is presented, pop its expectation and check.
    always @(negedge clk_i) begin
        if (strobe) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard_underflow: got empty queue, want an expectation");
            end else begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus and queue the expected lookup response.
    task automatic applyStimulus(input string name, input logic [31:0] pc,
                                 input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt,
                                 input logic clr, input logic eh, input logic et,
                                 input logic [31:0] en, input logic eb);
        exp_t e;
        lookup_pc_i  = pc;
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_taken_i  = ut;
        upd_target_i = utgt;
        clear_i      = clr;
        e.name  = name;
        e.hit   = eh;
        e.taken = et;
        e.next  = en;
        e.busy  = eb;
        sb_q.push_back(e);
        strobe = 1'b1;
        @(posedge clk_i);
        #1;
        strobe       = 1'b0;
        upd_valid_i  = 1'b0;
        clear_i      = 1'b0;
    endtask

    // Watchdog: the run is short, so any hang is reported and stopped.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, want $finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        strobe       = 1'b0;
        rst_n_i      = 1'b0;
        clear_i      = 1'b0;
        lookup_pc_i  = '0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        upd_target_i = '0;
`ifdef BP_STATS_EN
        upd_pred_taken_i = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // Reset sweep: busy for exactly 16 cycles, lookups forced to fall-through.
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus("reset_sweep_busy", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                          1'b0, 1'b0, 32'h44, 1'b1);
        end
        applyStimulus("reset_lookup_miss", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'h44, 1'b0);

        // Allocation; same-cycle lookup sees pre-update contents.
        applyStimulus("alloc_same_cycle", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b0, 1'b0, 32'h44, 1'b0);
        applyStimulus("alloc_hit", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);

        // Hysteresis: 10 -> 01 -> 00 -> 01 -> 10.
        applyStimulus("hyst_nt1_pre", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("hyst_cnt01", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("hyst_cnt00", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("hyst_cnt01b", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("hyst_cnt10", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);

        // Upper saturation: 5 taken from 10 -> 11, then one not-taken -> 10.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("sat_taken_run", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                          1'b1, 1'b1, 32'h100, 1'b0);
        end
        applyStimulus("sat_cnt11", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("sat_cnt10", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        // From 10: T,T (11,11), NT,NT (10,01) -> not taken; a wrapping counter would differ.
        applyStimulus("sat_hi_t1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("sat_hi_t2", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("sat_hi_nt1", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("sat_hi_nt2", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus("sat_hi_cnt01", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        // Lower saturation: 01 -> NT,NT (00,00) -> T (01) not taken -> T (10) taken.
        applyStimulus("sat_lo_nt1", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("sat_lo_nt2", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("sat_lo_t1", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("sat_lo_cnt01", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0,
                      1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus("sat_lo_cnt10", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h100, 1'b0);

        // Aliasing: 0x80 maps to index 0 with tag 2 (0x40 has tag 1).
        applyStimulus("alias_miss", 32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0,
                      1'b0, 1'b0, 32'h84, 1'b0);
        applyStimulus("alias_replaced", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h200, 1'b0);
        applyStimulus("alias_evicted", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'h44, 1'b0);
        // Not-taken misses (0xC4 -> index 1; 0x40 vs resident 0x80) must not allocate.
        applyStimulus("nt_miss_upd", 32'hC4, 1'b1, 32'hC4, 1'b0, 32'h300, 1'b0,
                      1'b0, 1'b0, 32'hC8, 1'b0);
        applyStimulus("nt_miss_noalloc", 32'hC4, 1'b1, 32'h40, 1'b0, 32'h400, 1'b0,
                      1'b0, 1'b0, 32'hC8, 1'b0);
        applyStimulus("nt_miss_keep", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b1, 1'b1, 32'h200, 1'b0);
        applyStimulus("nt_miss_no40", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'h44, 1'b0);

        // Clear with a same-cycle update: update dropped, 16 busy cycles.
        applyStimulus("clear_cycle", 32'h80, 1'b1, 32'hC4, 1'b1, 32'h300, 1'b1,
                      1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus("clear_sweep_busy", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                          1'b0, 1'b0, 32'h84, 1'b1);
        end
        applyStimulus("clear_miss_80", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'h84, 1'b0);
        applyStimulus("clear_drop_c4", 32'hC4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'hC8, 1'b0);

`ifdef BP_STATS_EN
        vectors++;
        if (stat_updates_o !== 32'd0 || stat_mispred_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL stats_after_clear: got upd=%0d misp=%0d, want upd=0 misp=0",
                     stat_updates_o, stat_mispred_o);
        end
        upd_pred_taken_i = 1'b0;
`endif

        // Re-allocate, then clear and restart the sweep at sweep cycle 5.
        applyStimulus("realloc", 32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0,
                      1'b0, 1'b0, 32'h84, 1'b0);
        applyStimulus("realloc_hit", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,
                      1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("restart_pre_busy", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                          1'b0, 1'b0, 32'h84, 1'b1);
        end
        applyStimulus("restart_clear", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,
                      1'b0, 1'b0, 32'h84, 1'b1);
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus("restart_busy", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                          1'b0, 1'b0, 32'h84, 1'b1);
        end
        applyStimulus("restart_done_miss", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                      1'b0, 1'b0, 32'h84, 1'b0);

`ifdef BP_STATS_EN
        vectors++;
        if (stat_updates_o !== 32'd0 || stat_mispred_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL stats_after_restart: got upd=%0d misp=%0d, want upd=0 misp=0",
                     stat_updates_o, stat_mispred_o);
        end
`endif

        // Every queued expectation must have been consumed by the monitor.
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
